// File: rtl/qif_neuron_array_if.sv
// -----------------------------------------------------------------------------
// qif_neuron_array_if
// Request/response bundle for the time-multiplexed QIF neuron array.
//
// Parameters
//   W     membrane / current word width (signed two's complement)
//   N_CH  number of neuron channels; channel fields are log2(N_CH) bits, min 1
//
// Signals
//   in_valid   request present                 (master -> slave)
//   in_ready   request accepted this edge      (slave  -> master)
//   in_ch      channel to update               (master -> slave)
//   in_isyn    signed synaptic current         (master -> slave)
//   out_valid  result present                  (slave  -> master)
//   out_ready  result consumed this edge       (master -> slave)
//   out_ch     channel of the result           (slave  -> master)
//   out_v      signed updated membrane value   (slave  -> master)
//   out_spike  the step fired                  (slave  -> master)
// -----------------------------------------------------------------------------
interface qif_neuron_array_if #(
    parameter int W    = 8,
    parameter int N_CH = 4
) ();

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [CH_W-1:0]        in_ch;
    logic signed [W-1:0]    in_isyn;

    logic                   out_valid;
    logic                   out_ready;
    logic [CH_W-1:0]        out_ch;
    logic signed [W-1:0]    out_v;
    logic                   out_spike;

    // The requester / result consumer side.
    modport master (
        output in_valid,
        output in_ch,
        output in_isyn,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_ch,
        input  out_v,
        input  out_spike
    );

    // The neuron array side.
    modport slave (
        input  in_valid,
        input  in_ch,
        input  in_isyn,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_ch,
        output out_v,
        output out_spike
    );

endinterface

// File: rtl/qif_neuron_array.sv
// -----------------------------------------------------------------------------
// qif_neuron_array
// Time-multiplexed array of quadratic integrate-and-fire neurons. Each accepted
// request performs one integration step on one channel:
//   v >= V_TH : v' = V_RESET, spike
//   otherwise : v' = sat(v + ((v >>> SHIFT) * (v >>> SHIFT)) + (isyn >>> 2))
// The step travels through a request stage, an operand stage (membrane read
// with forwarding) and the output register, so a result appears two edges
// after acceptance. Back-pressure from the output freezes the whole pipe.
//
// Optional feature (compile-time macro QIF_REFRAC_EN):
//   adds a per-channel refractory counter; after a spike the next REFRAC steps
//   of that channel hold v at V_RESET without firing.
//
// Parameters
//   W, N_CH, SHIFT, V_RESET, V_TH, REFRAC (REFRAC used only with QIF_REFRAC_EN)
//
// Ports
//   clk    clock, rising edge
//   rst_n  asynchronous reset, active high (historical name)
//   bus    qif_neuron_array_if.slave: request (in_*) and result (out_*) channels
// -----------------------------------------------------------------------------
module qif_neuron_array #(
    parameter int W       = 8,
    parameter int N_CH    = 4,
    parameter int SHIFT   = 3,
    parameter int V_RESET = -20,
    parameter int V_TH    = 50,
    parameter int REFRAC  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    qif_neuron_array_if.slave  bus
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int DEPTH = 1 << CH_W;
    localparam int AW    = 2 * W + 2;

    localparam logic signed [W-1:0]  V_RST_W = W'(V_RESET);
    localparam logic signed [W-1:0]  V_TH_W  = W'(V_TH);
    localparam logic signed [AW-1:0] SAT_MAX = $signed({{(AW-W+1){1'b0}}, {(W-1){1'b1}}});
    localparam logic signed [AW-1:0] SAT_MIN = $signed({{(AW-W+1){1'b1}}, {(W-1){1'b0}}});

`ifdef QIF_REFRAC_EN
    localparam int              R_W      = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [R_W-1:0]  REFRAC_W = R_W'(REFRAC);
`endif

    logic                   w_advance;
    logic                   w_inReady;
    logic                   w_accept;

    logic                   r_s1Valid;
    logic [CH_W-1:0]        r_s1Ch;
    logic signed [W-1:0]    r_s1Isyn;

    logic                   r_s2Valid;
    logic [CH_W-1:0]        r_s2Ch;
    logic signed [W-1:0]    r_s2Isyn;
    logic signed [W-1:0]    r_s2V;

    logic                   r_outValid;
    logic [CH_W-1:0]        r_outCh;
    logic signed [W-1:0]    r_outV;
    logic                   r_outSpike;

    logic signed [W-1:0]    r_vMem [DEPTH];

    logic                   w_fwd;
    logic signed [W-1:0]    w_opV;
    logic signed [W-1:0]    w_nextV;
    logic                   w_nextSpike;

    logic signed [AW-1:0]   w_vExt;
    logic signed [AW-1:0]   w_vScaled;
    logic signed [AW-1:0]   w_sq;
    logic signed [AW-1:0]   w_isynExt;
    logic signed [AW-1:0]   w_isynTerm;
    logic signed [AW-1:0]   w_sum;
    logic signed [W-1:0]    w_satV;

`ifdef QIF_REFRAC_EN
    logic [R_W-1:0]         r_rMem [DEPTH];
    logic [R_W-1:0]         r_s2R;
    logic [R_W-1:0]         w_opR;
    logic [R_W-1:0]         w_nextR;
`endif

    // A held result blocks everything behind it; the request port is closed
    // while reset is asserted so nothing is accepted into a clearing pipe.
    assign w_advance = !(r_outValid && !bus.out_ready);
    assign w_inReady = !rst_n && w_advance;
    assign w_accept  = bus.in_valid && w_inReady;

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_ch    = r_outCh;
    assign bus.out_v     = r_outV;
    assign bus.out_spike = r_outSpike;

    // Quadratic integration in 2W+2 bits so the square and the sums can never
    // wrap; sign extension is explicit so the shifts stay arithmetic.
    assign w_vExt     = {{(AW-W){r_s2V[W-1]}}, r_s2V};
    assign w_isynExt  = {{(AW-W){r_s2Isyn[W-1]}}, r_s2Isyn};
    assign w_vScaled  = w_vExt >>> SHIFT;
    assign w_sq       = w_vScaled * w_vScaled;
    assign w_isynTerm = w_isynExt >>> 2;
    assign w_sum      = w_vExt + w_sq + w_isynTerm;

    // Clamp the wide sum back into the W-bit signed range.
    always_comb begin
        w_satV = w_sum[W-1:0];
        if (w_sum > SAT_MAX) begin
            w_satV = SAT_MAX[W-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_satV = SAT_MIN[W-1:0];
        end
    end

    // Step decision for the operand stage: refractory hold (when built in),
    // threshold crossing with reset-to-V_RESET, or the saturated integration.
    always_comb begin
        w_nextV     = V_RST_W;
        w_nextSpike = 1'b0;
`ifdef QIF_REFRAC_EN
        w_nextR     = '0;
        if (r_s2R != '0) begin
            w_nextR = r_s2R - R_W'(1);
        end else if (r_s2V >= V_TH_W) begin
            w_nextSpike = 1'b1;
            w_nextR     = REFRAC_W;
        end else begin
            w_nextV = w_satV;
        end
`else
        if (r_s2V >= V_TH_W) begin
            w_nextSpike = 1'b1;
        end else begin
            w_nextV = w_satV;
        end
`endif
    end

    // The step in the operand stage writes the array on the same edge the step
    // in the request stage fetches, so a same-channel follower must take the
    // freshly computed value instead of the array contents.
    assign w_fwd = r_s2Valid && (r_s2Ch == r_s1Ch);
    assign w_opV = w_fwd ? w_nextV : r_vMem[r_s1Ch];
`ifdef QIF_REFRAC_EN
    assign w_opR = w_fwd ? w_nextR : r_rMem[r_s1Ch];
`endif

    // Pipeline registers: request stage, operand stage and output register all
    // move together and freeze together under back-pressure. Data fields only
    // load behind a valid step so the outputs stay quiet across bubbles.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_s1Valid  <= 1'b0;
            r_s1Ch     <= '0;
            r_s1Isyn   <= '0;
            r_s2Valid  <= 1'b0;
            r_s2Ch     <= '0;
            r_s2Isyn   <= '0;
            r_s2V      <= '0;
            r_outValid <= 1'b0;
            r_outCh    <= '0;
            r_outV     <= '0;
            r_outSpike <= 1'b0;
        end else if (w_advance) begin
            r_s1Valid  <= w_accept;
            if (w_accept) begin
                r_s1Ch   <= bus.in_ch;
                r_s1Isyn <= bus.in_isyn;
            end
            r_s2Valid  <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Ch   <= r_s1Ch;
                r_s2Isyn <= r_s1Isyn;
                r_s2V    <= w_opV;
            end
            r_outValid <= r_s2Valid;
            if (r_s2Valid) begin
                r_outCh    <= r_s2Ch;
                r_outV     <= w_nextV;
                r_outSpike <= w_nextSpike;
            end
        end
    end

`ifdef QIF_REFRAC_EN
    // Refractory operand follows the membrane operand through the pipe.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_s2R <= '0;
        end else if (w_advance && r_s1Valid) begin
            r_s2R <= w_opR;
        end
    end

    // Refractory counters are committed alongside the membrane values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rMem[i] <= '0;
            end
        end else if (w_advance && r_s2Valid) begin
            r_rMem[r_s2Ch] <= w_nextR;
        end
    end
`endif

    // Membrane array: written exactly once per step, when it moves into the
    // output register; a stalled output never writes again.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vMem[i] <= V_RST_W;
            end
        end else if (w_advance && r_s2Valid) begin
            r_vMem[r_s2Ch] <= w_nextV;
        end
    end

endmodule

// File: tb/tb_qif_neuron_array.sv
// -----------------------------------------------------------------------------
// tb_qif_neuron_array
// Scoreboard bench for qif_neuron_array. Two instances share clock, reset and
// stimulus: instance A uses the default threshold, instance B raises V_TH to
// 127 so a channel can climb far enough to reach the positive saturation
// limit. Expected results come from a sequential golden model updated at the
// moment each request is accepted and are compared in order as results leave.
// -----------------------------------------------------------------------------
module tb_qif_neuron_array;

    localparam int W       = 8;
    localparam int N_CH    = 4;
    localparam int CH_W    = 2;
    localparam int SHIFT   = 3;
    localparam int V_RESET = -20;
    localparam int V_TH_A  = 50;
    localparam int V_TH_B  = 127;
    localparam int REFRAC  = 2;

    typedef struct {
        int ch;
        int v;
        int spike;
    } item_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    qif_neuron_array_if #(.W(W), .N_CH(N_CH)) busA ();
    qif_neuron_array_if #(.W(W), .N_CH(N_CH)) busB ();

    qif_neuron_array #(
        .W(W), .N_CH(N_CH), .SHIFT(SHIFT), .V_RESET(V_RESET),
        .V_TH(V_TH_A), .REFRAC(REFRAC)
    ) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    qif_neuron_array #(
        .W(W), .N_CH(N_CH), .SHIFT(SHIFT), .V_RESET(V_RESET),
        .V_TH(V_TH_B), .REFRAC(REFRAC)
    ) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    int    checks = 0;
    int    errors = 0;
    item_t qA[$];
    item_t qB[$];
    int    mV [2][N_CH];
    int    mR [2][N_CH];
    int    sInReady [2];
    int    sOutValid [2];
    int    sOutCh [2];
    int    sOutV [2];
    int    sOutSpike [2];
    int    sawSpikeA = 0;
    int    sawSatB = 0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Safety net against a hung pipeline.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=summary");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Golden model state back to its reset values.
    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < N_CH; c++) begin
                mV[k][c] = V_RESET;
                mR[k][c] = 0;
            end
        end
    endtask

    // Sequential golden model for one step on instance k.
    task automatic modelStep(input int k, input int ch, input int isyn, output item_t it);
        int v;
        int vs;
        int sum;
        int vth;
        vth = (k == 0) ? V_TH_A : V_TH_B;
        v = mV[k][ch];
        it.ch = ch;
        it.spike = 0;
        it.v = V_RESET;
`ifdef QIF_REFRAC_EN
        if (mR[k][ch] > 0) begin
            mR[k][ch] = mR[k][ch] - 1;
        end else if (v >= vth) begin
            it.spike = 1;
            mR[k][ch] = REFRAC;
        end else begin
            vs = v >>> SHIFT;
            sum = v + vs * vs + (isyn >>> 2);
            it.v = (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
            mR[k][ch] = 0;
        end
`else
        if (v >= vth) begin
            it.spike = 1;
        end else begin
            vs = v >>> SHIFT;
            sum = v + vs * vs + (isyn >>> 2);
            it.v = (sum > 127) ? 127 : ((sum < -128) ? -128 : sum);
        end
`endif
        mV[k][ch] = it.v;
    endtask

    function automatic int queueSize(input int k);
        return (k == 0) ? qA.size() : qB.size();
    endfunction

    // One clock cycle: drive at the falling edge, sample shortly before the
    // rising edge, score accepts and consumed results, then wait for the next
    // falling edge.
    task automatic applyStimulus(input logic valid, input int ch, input int isyn, input logic oRdy);
        item_t it;
        busA.in_valid  = valid;
        busA.in_ch     = CH_W'(ch);
        busA.in_isyn   = W'(isyn);
        busA.out_ready = oRdy;
        busB.in_valid  = valid;
        busB.in_ch     = CH_W'(ch);
        busB.in_isyn   = W'(isyn);
        busB.out_ready = oRdy;
        #4;
        sInReady[0]  = int'(busA.in_ready);
        sOutValid[0] = int'(busA.out_valid);
        sOutCh[0]    = int'(busA.out_ch);
        sOutV[0]     = int'(busA.out_v);
        sOutSpike[0] = int'(busA.out_spike);
        sInReady[1]  = int'(busB.in_ready);
        sOutValid[1] = int'(busB.out_valid);
        sOutCh[1]    = int'(busB.out_ch);
        sOutV[1]     = int'(busB.out_v);
        sOutSpike[1] = int'(busB.out_spike);
        for (int k = 0; k < 2; k++) begin
            if (valid && sInReady[k] == 1) begin
                modelStep(k, ch, isyn, it);
                if (k == 0) qA.push_back(it);
                else        qB.push_back(it);
            end
            if (sOutValid[k] == 1 && oRdy) begin
                if (queueSize(k) == 0) begin
                    checkOutput((k == 0) ? "A_unexpected_out" : "B_unexpected_out", 1, 0);
                end else begin
                    if (k == 0) it = qA.pop_front();
                    else        it = qB.pop_front();
                    checkOutput((k == 0) ? "A_out_ch" : "B_out_ch", sOutCh[k], it.ch);
                    checkOutput((k == 0) ? "A_out_v" : "B_out_v", sOutV[k], it.v);
                    checkOutput((k == 0) ? "A_out_spike" : "B_out_spike", sOutSpike[k], it.spike);
                    if (k == 0 && sOutCh[k] == 1 && sOutSpike[k] == 1) sawSpikeA = 1;
                    if (k == 1 && sOutCh[k] == 2 && sOutV[k] == 127) sawSatB = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Idle cycles until both scoreboards are empty, with a cycle budget.
    task automatic drainPipe();
        int budget;
        budget = 0;
        while ((qA.size() != 0 || qB.size() != 0) && budget < 40) begin
            applyStimulus(1'b0, 0, 0, 1'b1);
            budget++;
        end
        checkOutput("drain_A_left", qA.size(), 0);
        checkOutput("drain_B_left", qB.size(), 0);
    endtask

    initial begin
        int guard;
        int heldCh;
        int heldV;
        int heldSpike;

        busA.in_valid = 1'b0; busA.in_ch = '0; busA.in_isyn = '0; busA.out_ready = 1'b1;
        busB.in_valid = 1'b0; busB.in_ch = '0; busB.in_isyn = '0; busB.out_ready = 1'b1;
        resetModel();

        // Reset state of the outputs.
        repeat (3) @(negedge clk);
        checkOutput("rst_A_out_valid", int'(busA.out_valid), 0);
        checkOutput("rst_A_out_ch", int'(busA.out_ch), 0);
        checkOutput("rst_A_out_v", int'(busA.out_v), 0);
        checkOutput("rst_A_out_spike", int'(busA.out_spike), 0);
        checkOutput("rst_A_in_ready", int'(busA.in_ready), 0);
        checkOutput("rst_B_out_valid", int'(busB.out_valid), 0);
        checkOutput("rst_B_in_ready", int'(busB.in_ready), 0);
        rst_n = 1'b0;

        // First step on ch0 with zero current: accepted right after reset,
        // result two edges later.
        applyStimulus(1'b1, 0, 0, 1'b1);
        checkOutput("first_accept", sInReady[0], 1);
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("lat_edge1_valid", sOutValid[0], 0);
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("lat_edge2_valid", sOutValid[0], 0);
        applyStimulus(1'b0, 0, 0, 1'b1);
        checkOutput("lat_result_valid", sOutValid[0], 1);
        checkOutput("first_out_v", sOutV[0], -11);
        checkOutput("first_out_spike", sOutSpike[0], 0);
        drainPipe();

        // Charge ch1 back-to-back until it crosses threshold, then fire.
        guard = 0;
        while (mV[0][1] < V_TH_A && guard < 16) begin
            applyStimulus(1'b1, 1, 40, 1'b1);
            guard++;
        end
        applyStimulus(1'b1, 1, 40, 1'b1);
`ifdef QIF_REFRAC_EN
        applyStimulus(1'b1, 1, 40, 1'b1);
        applyStimulus(1'b1, 1, 40, 1'b1);
`endif
        drainPipe();
        checkOutput("A_ch1_spiked", sawSpikeA, 1);

        // Drive ch2 hard; instance B climbs past 120 and clamps at 127.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2, 127, 1'b1);
        end
        drainPipe();
        checkOutput("B_ch2_saturated", sawSatB, 1);

        // Same channel on three consecutive cycles exercises forwarding.
        applyStimulus(1'b1, 3, 16, 1'b1);
        applyStimulus(1'b1, 3, -40, 1'b1);
        applyStimulus(1'b1, 3, 100, 1'b1);
        applyStimulus(1'b1, 0, 64, 1'b1);
        applyStimulus(1'b1, 3, 8, 1'b1);
        drainPipe();

        // Back-pressure: fill, then hold out_ready low for five cycles.
        applyStimulus(1'b1, 0, 12, 1'b1);
        applyStimulus(1'b1, 0, 20, 1'b1);
        applyStimulus(1'b1, 1, -8, 1'b1);
        heldCh = 0;
        heldV = 0;
        heldSpike = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 0, 8, 1'b0);
            checkOutput("stall_in_ready", sInReady[0], 0);
            checkOutput("stall_out_valid", sOutValid[0], 1);
            if (i == 0) begin
                heldCh = sOutCh[0];
                heldV = sOutV[0];
                heldSpike = sOutSpike[0];
            end else begin
                checkOutput("stall_hold_ch", sOutCh[0], heldCh);
                checkOutput("stall_hold_v", sOutV[0], heldV);
                checkOutput("stall_hold_spike", sOutSpike[0], heldSpike);
            end
        end
        applyStimulus(1'b1, 0, 8, 1'b1);
        drainPipe();

        // Mixed traffic with random back-pressure.
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, N_CH - 1)),
                          int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 3) != 0));
        end
        drainPipe();

        // Reset with two steps in flight: pipeline cleared, channels restored.
        applyStimulus(1'b1, 0, 60, 1'b1);
        applyStimulus(1'b1, 1, 60, 1'b1);
        busA.in_valid = 1'b0;
        busB.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_A_out_valid", int'(busA.out_valid), 0);
        checkOutput("midrst_A_in_ready", int'(busA.in_ready), 0);
        checkOutput("midrst_A_out_v", int'(busA.out_v), 0);
        checkOutput("midrst_B_out_valid", int'(busB.out_valid), 0);
        qA.delete();
        qB.delete();
        resetModel();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            applyStimulus(1'b1, c, 0, 1'b1);
            checkOutput("postrst_accept", sInReady[0], 1);
        end
        drainPipe();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/qif_neuron_array.md
QIF_NEURON_ARRAY -- requirements
Module: qif_neuron_array

Interface
REQ-001 Parameter W, default 8: membrane/current word width, signed two's complement.
REQ-002 Parameter N_CH, default 4: number of time-multiplexed neuron channels (power of 2, 1..64).
REQ-003 Parameter SHIFT, default 3: quadratic pre-scale; sq = (v >>> SHIFT) * (v >>> SHIFT).
REQ-004 Parameter V_RESET, default -20: post-spike/reset potential, W-bit signed.
REQ-005 Parameter V_TH, default 50: spike threshold, W-bit signed.
REQ-006 Parameter REFRAC, default 2: refractory steps after a spike (used only with QIF_REFRAC_EN).
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-high.
REQ-009 in_valid  input  1  update request present.
REQ-010 in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
REQ-011 in_ch  input  log2(N_CH) (min 1)  channel to update.
REQ-012 in_isyn  input  W  signed synaptic current for this step.
REQ-013 out_valid  output  1  result present.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-015 out_ch  output  log2(N_CH)  channel of result.
REQ-016 out_v  output  W  signed updated membrane value of out_ch.
REQ-017 out_spike  output  1  1 when this step fired.

Function
REQ-018 Per-channel state: membrane v[ch] (W bits), refractory count r[ch]; one integration step per accepted request.
REQ-019 Step, v = current v[ch]: if v >= V_TH then v' = V_RESET, spike = 1; else v' = sat_W(v + sq + (in_isyn >>> 2)), spike = 0.
REQ-020 Arithmetic in 2W+2 signed bits; sat_W clamps to [-2^(W-1), 2^(W-1)-1]; no wrap-around ever.
REQ-021 Two-stage pipeline: request accepted at edge t yields out_valid with its result after edge t+2 (latency 2), in acceptance order.
REQ-022 Back-to-back requests to the same channel (edges t, t+1) SHALL use forwarded v'/r' from the older step, never stale array contents.
REQ-023 in_ready = !(out_valid && !out_ready); stall freezes both stages and all outputs, loses no data.
REQ-024 Array write of v'/r' occurs when a step enters the output stage; held output never re-writes.
REQ-025 Throughput: one step per cycle while out_ready = 1.

Reset
REQ-026 On rst_n = 1 (asynchronous): every v[ch] = V_RESET, r[ch] = 0, pipeline emptied.
REQ-027 During reset out_valid = 0, out_ch = 0, out_v = 0, out_spike = 0, in_ready = 0.
REQ-028 Reset mid-operation discards all in-flight steps; first acceptance possible at first edge after rst_n falls.

Configuration
REQ-029 Macro QIF_REFRAC_EN: when defined, a step on a channel with r[ch] > 0 yields v' = V_RESET, spike = 0, r' = r - 1; a spiking step sets r' = REFRAC.
REQ-030 Without QIF_REFRAC_EN: r[ch] storage absent, REFRAC ignored, behaviour per REQ-019 only.

Verification
REQ-031 Reset, ch0 isyn=0 -> out_v = -20+((-3)*(-3))+0 = -11, spike 0, out_valid 2 cycles after accept.
REQ-032 ch1 driven isyn=40 every step until v>=50 -> next step out_v = -20, out_spike = 1; with QIF_REFRAC_EN next two steps out_v = -20, spike 0.
REQ-033 ch2 v near 120, isyn=127 -> out_v saturates at 127, no wrap to negative.
REQ-034 Same channel on 3 consecutive cycles -> results match sequential golden model (forwarding check).
REQ-035 out_ready held 0 for 5 cycles with in_valid high -> in_ready 0, out_* stable, no step lost or duplicated.
REQ-036 rst_n pulsed with 2 steps in flight -> out_valid 0, all channels read back -20 on next steps.
